cursor_overlay: RTL and testbench

CURSOR_OVERLAY -- requirements
Module: cursor_overlay

---
 rtl/cursor_overlay_pkg.sv | 25 ++
 rtl/cursor_bitmap_ram.sv | 21 ++
 rtl/cursor_overlay.sv | 147 ++++++++++++++
 tb/tb_cursor_overlay.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_overlay_pkg.sv
// rtl/cursor_overlay_pkg.sv - shared cursor codes, size constant and pixel colour type
package cursor_overlay_pkg;

  localparam int CURSOR_SIZE = 32;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    TRANSPARENT = 2'b00,
    COLOR1      = 2'b01,
    COLOR2      = 2'b10,
    INVERT      = 2'b11
  } cur_code_t;

  // Composite one cursor code over the underlying video pixel.
  function automatic rgb_t apply_code(cur_code_t code, rgb_t under, rgb_t c1, rgb_t c2);
    case (code)
      COLOR1:  return c1;
      COLOR2:  return c2;
      INVERT:  return ~under;
      default: return under;
    endcase
  endfunction

endpackage

// File: rtl/cursor_bitmap_ram.sv
// rtl/cursor_bitmap_ram.sv - 64x32 cursor bitmap, one write port, one registered read port
module cursor_bitmap_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [0:63];

  // Non-blocking read and write in one process: a same-word read returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cursor_overlay.sv
// rtl/cursor_overlay.sv - two-stage hardware cursor compositor on a pixel stream
module cursor_overlay
  import cursor_overlay_pkg::*;
#(
  parameter int CUR_SIZE = CURSOR_SIZE,
  parameter int COORD_W  = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               visible_i,
  input  logic               end_of_line_i,
  input  logic               end_of_frame_i,
  input  logic               hsync_n_i,
  input  logic               vsync_n_i,
  input  logic [23:0]        rgb_i,
  input  logic               cur_en_i,
  input  logic [COORD_W-1:0] cur_x_i,
  input  logic [COORD_W-1:0] cur_y_i,
  input  logic [23:0]        color1_i,
  input  logic [23:0]        color2_i,
  input  logic               bm_we_i,
  input  logic [5:0]         bm_addr_i,
  input  logic [31:0]        bm_data_i,
  output logic               visible_o,
  output logic               end_of_line_o,
  output logic               end_of_frame_o,
  output logic               hsync_n_o,
  output logic               vsync_n_o,
  output logic [23:0]        rgb_o
);

  localparam logic [COORD_W-1:0] SIZE_LIM = COORD_W'(CUR_SIZE);

  logic [COORD_W-1:0] x_q, y_q, sx_q, sy_q;
  logic               sen_q, line_vis_q;
  logic [COORD_W-1:0] dx, dy;
  logic               hit0;
  logic [5:0]         rd_addr;
  logic [31:0]        bm_rdata;

  logic               vis1_q, eol1_q, eof1_q, hs1_q, vs1_q, hit1_q;
  rgb_t               rgb1_q;
  logic [3:0]         pix1_q;
  logic [4:0]         sel_lsb;
  cur_code_t          code;

  // Raster counters and the per-frame position shadow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q        <= '0;
      y_q        <= '0;
      line_vis_q <= 1'b0;
      sen_q      <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
    end else begin
      if (end_of_line_i) begin
        x_q <= '0;
      end else if (visible_i) begin
        x_q <= x_q + 1'b1;
      end

      if (end_of_frame_i) begin
        y_q <= '0;
      end else if (end_of_line_i && (line_vis_q || visible_i)) begin
        y_q <= y_q + 1'b1;
      end

      if (end_of_line_i) begin
        line_vis_q <= 1'b0;
      end else if (visible_i) begin
        line_vis_q <= 1'b1;
      end

      if (end_of_frame_i) begin
        sen_q <= cur_en_i;
        sx_q  <= cur_x_i;
        sy_q  <= cur_y_i;
      end
    end
  end

  // Modular differences make positions past the visible edge clip without extra logic.
  assign dx      = x_q - sx_q;
  assign dy      = y_q - sy_q;
  assign hit0    = visible_i & sen_q & (dx < SIZE_LIM) & (dy < SIZE_LIM);
  assign rd_addr = {dy[4:0], dx[4]};

  cursor_bitmap_ram u_bitmap (
    .clk   (clk_i),
    .we    (bm_we_i),
    .waddr (bm_addr_i),
    .wdata (bm_data_i),
    .raddr (rd_addr),
    .rdata (bm_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vis1_q <= 1'b0;
      eol1_q <= 1'b0;
      eof1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      rgb1_q <= '0;
      hit1_q <= 1'b0;
      pix1_q <= '0;
    end else begin
      vis1_q <= visible_i;
      eol1_q <= end_of_line_i;
      eof1_q <= end_of_frame_i;
      hs1_q  <= hsync_n_i;
      vs1_q  <= vsync_n_i;
      rgb1_q <= rgb_i;
      hit1_q <= hit0;
      pix1_q <= dx[3:0];
    end
  end

  assign sel_lsb = {pix1_q, 1'b0};

  always_comb begin
    code = TRANSPARENT;
    if (hit1_q) begin
      code = cur_code_t'(bm_rdata[sel_lsb +: 2]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      visible_o      <= 1'b0;
      end_of_line_o  <= 1'b0;
      end_of_frame_o <= 1'b0;
      hsync_n_o      <= 1'b1;
      vsync_n_o      <= 1'b1;
      rgb_o          <= '0;
    end else begin
      visible_o      <= vis1_q;
      end_of_line_o  <= eol1_q;
      end_of_frame_o <= eof1_q;
      hsync_n_o      <= hs1_q;
      vsync_n_o      <= vs1_q;
      rgb_o          <= vis1_q ? apply_code(code, rgb1_q, color1_i, color2_i) : '0;
    end
  end

endmodule

// File: tb/tb_cursor_overlay.sv
// tb/tb_cursor_overlay.sv - randomized self-checking bench for cursor_overlay
module tb_cursor_overlay;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        visible_i = 1'b0, end_of_line_i = 1'b0, end_of_frame_i = 1'b0;
  logic        hsync_n_i = 1'b1, vsync_n_i = 1'b1;
  logic [23:0] rgb_i = '0;
  logic        cur_en_i = 1'b0;
  logic [9:0]  cur_x_i = '0, cur_y_i = '0;
  logic [23:0] color1_i = '0, color2_i = '0;
  logic        bm_we_i = 1'b0;
  logic [5:0]  bm_addr_i = '0;
  logic [31:0] bm_data_i = '0;
  logic        visible_o, end_of_line_o, end_of_frame_o, hsync_n_o, vsync_n_o;
  logic [23:0] rgb_o;

  always #5 clk = ~clk;

  cursor_overlay #(.CUR_SIZE(32), .COORD_W(10)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .visible_i      (visible_i),
    .end_of_line_i  (end_of_line_i),
    .end_of_frame_i (end_of_frame_i),
    .hsync_n_i      (hsync_n_i),
    .vsync_n_i      (vsync_n_i),
    .rgb_i          (rgb_i),
    .cur_en_i       (cur_en_i),
    .cur_x_i        (cur_x_i),
    .cur_y_i        (cur_y_i),
    .color1_i       (color1_i),
    .color2_i       (color2_i),
    .bm_we_i        (bm_we_i),
    .bm_addr_i      (bm_addr_i),
    .bm_data_i      (bm_data_i),
    .visible_o      (visible_o),
    .end_of_line_o  (end_of_line_o),
    .end_of_frame_o (end_of_frame_o),
    .hsync_n_o      (hsync_n_o),
    .vsync_n_o      (vsync_n_o),
    .rgb_o          (rgb_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: bitmap contents and the position that the last frame end captured.
  logic [31:0] m_mem [64];
  bit          m_en = 1'b0;
  int          m_sx = 0, m_sy = 0;
  logic [28:0] exp_q [$];
  bit          prev_rst = 1'b0;
  bit          rand_wr = 1'b0;
  bit          fixed_rgb = 1'b0;
  logic [23:0] rgb_const = '0;
  logic [23:0] mark_col = 24'hFF0000;
  int          mark_cnt = 0;
  int          cyc = 0;

  localparam logic [28:0] RST_VAL = {3'b000, 2'b11, 24'h000000};

  function automatic logic [23:0] model_pix(int x, int y, logic [23:0] under);
    int dx, dy;
    logic [31:0] word;
    int code;
    dx = (x - m_sx) & 1023;
    dy = (y - m_sy) & 1023;
    if (!m_en || dx >= 32 || dy >= 32) return under;
    word = m_mem[dy * 2 + dx / 16];
    code = int'((word >> (2 * (dx % 16))) & 32'd3);
    case (code)
      1:       return color1_i;
      2:       return color2_i;
      3:       return ~under;
      default: return under;
    endcase
  endfunction

  task automatic drive_cycle(bit vis, bit eol, bit eof, int x, int y, bit rst,
                             bit we_in, logic [5:0] wa_in, logic [31:0] wd_in);
    logic [28:0] e, got;
    bit          we;
    logic [5:0]  wa;
    logic [31:0] wd;
    we = we_in; wa = wa_in; wd = wd_in;
    if (rand_wr && !we) begin
      we = ($urandom % 4) == 0;
      wa = 6'($urandom);
      wd = $urandom;
    end
    @(posedge clk);
    #1;
    visible_i      = vis;
    end_of_line_i  = eol;
    end_of_frame_i = eof;
    hsync_n_i      = 1'($urandom);
    vsync_n_i      = 1'($urandom);
    rgb_i          = fixed_rgb ? rgb_const : {1'b0, 23'($urandom)};
    bm_we_i        = we;
    bm_addr_i      = wa;
    bm_data_i      = wd;
    rst_i          = rst;
    if (rst) begin
      if (!prev_rst) begin
        exp_q.delete();
        exp_q.push_back(RST_VAL);
        exp_q.push_back(RST_VAL);
      end
      m_en = 1'b0;
      e = RST_VAL;
    end else begin
      e = {vis, eol, eof, hsync_n_i, vsync_n_i, vis ? model_pix(x, y, rgb_i) : 24'h000000};
    end
    exp_q.push_back(e);
    if (we) m_mem[wa] = wd;
    if (eof && !rst) begin
      m_en = cur_en_i;
      m_sx = int'(cur_x_i);
      m_sy = int'(cur_y_i);
    end
    prev_rst = rst;
    @(negedge clk);
    got = {visible_o, end_of_line_o, end_of_frame_o, hsync_n_o, vsync_n_o, rgb_o};
    if (visible_o && rgb_o == mark_col) mark_cnt++;
    if (exp_q.size() >= 3) check($sformatf("out cyc%0d", cyc), 32'(got), 32'(exp_q.pop_front()));
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic fill(logic [31:0] v);
    for (int i = 0; i < 64; i++) drive_cycle(0, 0, 0, 0, 0, 0, 1, 6'(i), v);
  endtask

  // Lines inside [a0,a1] or [b0,b1] are W pixels wide, others 2; two blank lines end the frame.
  task automatic run_frame(int v, int w_full, int a0, int a1, int b0, int b1,
                           int chg_line, int chg_x, int chg_y, int rst_line, int rst_px);
    for (int y = 0; y < v + 2; y++) begin
      int w;
      w = (y >= v) ? 0 : (((y >= a0 && y <= a1) || (y >= b0 && y <= b1)) ? w_full : 2);
      for (int p = 0; p < w + 2; p++) begin
        bit r;
        r = (y == rst_line) && (p >= rst_px) && (p < rst_px + 3);
        if (y == chg_line && p == 0) begin
          cur_x_i = 10'(chg_x);
          cur_y_i = 10'(chg_y);
        end
        drive_cycle(p < w, p == w + 1, (p == w + 1) && (y == v + 1), p, y, r, 0, '0, '0);
      end
    end
  endtask

  task automatic load_pos(bit en, int x, int y);
    cur_en_i = en;
    cur_x_i  = 10'(x);
    cur_y_i  = 10'(y);
    run_frame(1, 2, -1, -1, -1, -1, -1, 0, 0, -1, 0);
  endtask

  initial begin
    repeat (4) drive_cycle(0, 0, 0, 0, 0, 1, 0, '0, '0);
    idle(3);

    // Cursor disabled: plain 2-cycle passthrough with random video.
    run_frame(20, 30, 0, 19, -1, -1, -1, 0, 0, -1, 0);
    load_pos(0, 5, 5);
    run_frame(20, 30, 0, 19, -1, -1, -1, 0, 0, -1, 0);

    // Solid colour-1 cursor at (100,50).
    fill(32'h55555555);
    color1_i = 24'hFF0000;
    color2_i = 24'h00FF00;
    mark_col = 24'hFF0000;
    load_pos(1, 100, 50);
    mark_cnt = 0;
    run_frame(90, 140, 48, 84, -1, -1, -1, 0, 0, -1, 0);
    check("solid_cnt", mark_cnt, 1024);

    // All-invert cursor over a constant colour at the origin.
    fill(32'hFFFFFFFF);
    fixed_rgb = 1'b1;
    rgb_const = 24'h123456;
    mark_col  = 24'hEDCBA9;
    load_pos(1, 0, 0);
    mark_cnt = 0;
    run_frame(40, 40, 0, 39, -1, -1, -1, 0, 0, -1, 0);
    check("invert_cnt", mark_cnt, 1024);
    fixed_rgb = 1'b0;

    // Bottom-right clipping in a 640x480 raster.
    fill(32'h55555555);
    mark_col = 24'hFF0000;
    load_pos(1, 630, 470);
    mark_cnt = 0;
    run_frame(480, 640, 0, 3, 465, 479, -1, 0, 0, -1, 0);
    check("clip_cnt", mark_cnt, 100);

    // Position change mid-frame only takes effect on the following frame.
    load_pos(1, 10, 10);
    mark_cnt = 0;
    run_frame(240, 240, 8, 14, 198, 204, 100, 200, 200, -1, 0);
    check("move_old_cnt", mark_cnt, 160);
    mark_cnt = 0;
    run_frame(240, 240, 8, 14, 198, 204, -1, 0, 0, -1, 0);
    check("move_new_cnt", mark_cnt, 160);

    // Random bitmaps, palettes and positions, with bitmap writes racing the reads.
    for (int f = 0; f < 2; f++) begin
      color1_i = 24'($urandom);
      color2_i = 24'($urandom);
      load_pos(($urandom % 4) != 0, $urandom_range(0, 70), $urandom_range(0, 50));
      rand_wr = 1'b1;
      run_frame(60, 80, 0, 59, -1, -1, -1, 0, 0, -1, 0);
      rand_wr = 1'b0;
    end

    // Reset mid-line, then drawing resumes after the next frame end.
    fill(32'h55555555);
    color1_i = 24'hFF0000;
    mark_col = 24'hFF0000;
    load_pos(1, 0, 0);
    run_frame(40, 50, 0, 39, -1, -1, -1, 0, 0, 20, 10);
    mark_cnt = 0;
    run_frame(40, 50, 0, 39, -1, -1, -1, 0, 0, -1, 0);
    check("post_rst_cnt", mark_cnt, 1024);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
